// File: rtl/gc_dram_refresh_ctrl_if.sv
// ---------------------------------------------------------------------------
// gc_dram_refresh_ctrl_if
// Bundles the user request/response bus and the gain-cell macro port of the
// refresh controller.
//   slave  : the controller (gc_dram_refresh_ctrl)
//   master : the environment, i.e. the user agent plus the DRAM macro
// Signals:
//   usr_req/usr_we/usr_addr/usr_wdata  user request (master -> slave)
//   usr_gnt                            combinational grant (slave -> master)
//   usr_rdata/usr_rvalid               read response (slave -> master)
//   mem_re/mem_we/mem_raddr/mem_waddr/mem_in  macro commands (slave -> master)
//   mem_rd                             macro read data (master -> slave)
// ---------------------------------------------------------------------------
interface gc_dram_refresh_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 64
);
    logic              usr_req;
    logic              usr_we;
    logic [ADDR_W-1:0] usr_addr;
    logic [DATA_W-1:0] usr_wdata;
    logic              usr_gnt;
    logic [DATA_W-1:0] usr_rdata;
    logic              usr_rvalid;

    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_raddr;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_in;
    logic [DATA_W-1:0] mem_rd;

    modport slave (
        input  usr_req, usr_we, usr_addr, usr_wdata, mem_rd,
        output usr_gnt, usr_rdata, usr_rvalid,
               mem_re, mem_we, mem_raddr, mem_waddr, mem_in
    );

    modport master (
        output usr_req, usr_we, usr_addr, usr_wdata, mem_rd,
        input  usr_gnt, usr_rdata, usr_rvalid,
               mem_re, mem_we, mem_raddr, mem_waddr, mem_in
    );
endinterface

// File: rtl/gc_dram_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// gc_dram_refresh_ctrl
// Front-end for the 128x64 gain-cell DRAM macro. Arbitrates single-port user
// reads/writes against periodic row refresh (read, capture, write-back).
// A credit is earned every REFRESH_INTERVAL cycles; user traffic wins until
// credits saturate at MAX_CREDIT, at which point refresh is forced. Rows the
// user wrote since the pointer last passed them are skipped (one cycle, no
// macro access) because the user write already restored their charge.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   bus          gc_dram_refresh_ctrl_if.slave (user bus + macro port)
//   ref_busy     high while a refresh sequence owns the macro
//   ref_overrun  sticky: a credit was earned while already saturated
// ---------------------------------------------------------------------------
module gc_dram_refresh_ctrl #(
    parameter int ROWS             = 128,
    parameter int ADDR_W           = 7,
    parameter int DATA_W           = 64,
    parameter int REFRESH_INTERVAL = 15,
    parameter int MAX_CREDIT       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gc_dram_refresh_ctrl_if.slave  bus,
    output logic                   ref_busy,
    output logic                   ref_overrun
);

    localparam int TICK_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam int CRED_W = $clog2(MAX_CREDIT + 1);

    typedef enum logic [1:0] {IDLE, REF_RD, REF_CAP, REF_WB} state_t;

    state_t              state, state_nxt;
    logic [TICK_W-1:0]   tick;
    logic [CRED_W-1:0]   credits;
    logic [ADDR_W-1:0]   ptr, ptr_inc;
    logic [ROWS-1:0]     dirty;

    logic                tick_wrap, credit_full, ref_want;
    logic                do_skip, do_start, grant, consume;

    logic                mem_re_q, mem_we_q, rd_pend, rvalid_q;
    logic [ADDR_W-1:0]   mem_raddr_q, mem_waddr_q;
    logic [DATA_W-1:0]   mem_in_q;

    assign tick_wrap   = (tick == TICK_W'(REFRESH_INTERVAL - 1));
    assign credit_full = (credits == CRED_W'(MAX_CREDIT));
    // Refresh yields to a pending user request unless credits are saturated.
    assign ref_want    = (state == IDLE) && (credits != '0) && (!bus.usr_req || credit_full);
    assign ptr_inc     = (ptr == ADDR_W'(ROWS - 1)) ? '0 : ptr + 1'b1;
    assign consume     = do_skip || do_start;

    // Next-state and grant decision; refresh is atomic so no grant outside IDLE.
    always_comb begin
        state_nxt = state;
        do_skip   = 1'b0;
        do_start  = 1'b0;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (ref_want) begin
                    if (dirty[ptr]) begin
                        do_skip = 1'b1;
                    end else begin
                        do_start  = 1'b1;
                        state_nxt = REF_RD;
                    end
                end else begin
                    grant = bus.usr_req;
                end
            end
            REF_RD:  state_nxt = REF_CAP;
            REF_CAP: state_nxt = REF_WB;
            REF_WB:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Free-running tick and credit bookkeeping; earn and spend in the same
    // cycle cancel out, even at saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick        <= '0;
            credits     <= '0;
            ref_overrun <= 1'b0;
        end else begin
            tick <= tick_wrap ? '0 : tick + 1'b1;
            if (tick_wrap && !consume && !credit_full)
                credits <= credits + 1'b1;
            else if (!tick_wrap && consume)
                credits <= credits - 1'b1;
            if (tick_wrap && credit_full)
                ref_overrun <= 1'b1;
        end
    end

    // Refresh pointer and dirty-row tracking. A skip and a user write can
    // never coincide because a skip withholds the grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            dirty <= '0;
        end else begin
            if (do_skip) begin
                dirty[ptr] <= 1'b0;
                ptr        <= ptr_inc;
            end else if (state == REF_WB) begin
                ptr <= ptr_inc;
            end
            if (grant && bus.usr_we)
                dirty[bus.usr_addr] <= 1'b1;
        end
    end

    // Registered macro commands. Only one source (user op, refresh read,
    // refresh write-back) is active in any cycle, so re/we never collide.
    // The write-back data is taken straight from mem_rd in REF_CAP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_raddr_q <= '0;
            mem_waddr_q <= '0;
            mem_in_q    <= '0;
            rd_pend     <= 1'b0;
            rvalid_q    <= 1'b0;
        end else begin
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;
            rd_pend  <= 1'b0;
            rvalid_q <= rd_pend;
            if (grant) begin
                if (bus.usr_we) begin
                    mem_we_q    <= 1'b1;
                    mem_waddr_q <= bus.usr_addr;
                    mem_in_q    <= bus.usr_wdata;
                end else begin
                    mem_re_q    <= 1'b1;
                    mem_raddr_q <= bus.usr_addr;
                    rd_pend     <= 1'b1;
                end
            end
            if (do_start) begin
                mem_re_q    <= 1'b1;
                mem_raddr_q <= ptr;
            end
            if (state == REF_CAP) begin
                mem_we_q    <= 1'b1;
                mem_waddr_q <= ptr;
                mem_in_q    <= bus.mem_rd;
            end
        end
    end

    assign bus.usr_gnt    = grant;
    assign bus.usr_rvalid = rvalid_q;
    assign bus.usr_rdata  = rvalid_q ? bus.mem_rd : '0;
    assign bus.mem_re     = mem_re_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_raddr  = mem_raddr_q;
    assign bus.mem_waddr  = mem_waddr_q;
    assign bus.mem_in     = mem_in_q;
    assign ref_busy       = (state != IDLE);

endmodule

// File: tb/tb_gc_dram_refresh_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gc_dram_refresh_ctrl
// Directed bench for gc_dram_refresh_ctrl. A behavioural macro model answers
// mem_re one cycle later. A second instance with REFRESH_INTERVAL=2 earns
// credits faster than refresh can spend them, which drives ref_overrun.
// ---------------------------------------------------------------------------
module tb_gc_dram_refresh_ctrl;

    localparam int ROWS   = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n_f = 1'b0;
    always #5 clk = ~clk;

    gc_dram_refresh_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus   ();
    gc_dram_refresh_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_f ();

    logic ref_busy, ref_overrun, ref_busy_f, ref_overrun_f;

    gc_dram_refresh_ctrl #(
        .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .REFRESH_INTERVAL(15), .MAX_CREDIT(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .ref_busy(ref_busy), .ref_overrun(ref_overrun)
    );

    gc_dram_refresh_ctrl #(
        .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .REFRESH_INTERVAL(2), .MAX_CREDIT(4)
    ) dut_fast (
        .clk(clk), .rst_n(rst_n_f), .bus(bus_f),
        .ref_busy(ref_busy_f), .ref_overrun(ref_overrun_f)
    );

    assign bus_f.usr_req   = 1'b0;
    assign bus_f.usr_we    = 1'b0;
    assign bus_f.usr_addr  = '0;
    assign bus_f.usr_wdata = '0;
    assign bus_f.mem_rd    = '0;

    int n_checks = 0;
    int n_pass   = 0;

    function automatic logic [63:0] pattern(int row);
        return {32'hC0DE0000 | 32'(row), 32'h12345678 ^ 32'(row)};
    endfunction

    // Macro model: loads its contents on the first edge, then writes on
    // mem_we and returns read data one cycle after the address.
    logic [63:0] mem [0:ROWS-1];
    bit mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < ROWS; i++) mem[i] <= pattern(i);
            mem_loaded <= 1'b1;
        end else if (bus.mem_we) begin
            mem[bus.mem_waddr] <= bus.mem_in;
        end
        bus.mem_rd <= mem[bus.mem_raddr];
    end

    // Expected {busy, re, we, raddr, waddr, mem_in} for an idle bus, cycle c
    // counted from reset release; tick n lands at edge 15n.
    function automatic logic [80:0] idle_expect(int c, int skip_tick,
                                                logic [63:0] row3_data, bit row3_new);
        int n, ph, row;
        logic [63:0] d;
        logic [6:0] r7;
        idle_expect = '0;
        n  = c / 15;
        ph = c % 15;
        if (n >= 1 && n != skip_tick && ph >= 1 && ph <= 3) begin
            row = (n - 1) % ROWS;
            r7  = row[6:0];
            d   = (row == 3 && row3_new) ? row3_data : pattern(row);
            idle_expect[80] = 1'b1;
            if (ph == 1) begin
                idle_expect[79]    = 1'b1;
                idle_expect[77:71] = r7;
            end
            if (ph == 3) begin
                idle_expect[78]    = 1'b1;
                idle_expect[70:64] = r7;
                idle_expect[63:0]  = d;
            end
        end
    endfunction

    function automatic logic [80:0] observe();
        return {ref_busy, bus.mem_re, bus.mem_we,
                bus.mem_re ? bus.mem_raddr : 7'd0,
                bus.mem_we ? bus.mem_waddr : 7'd0,
                bus.mem_we ? bus.mem_in : 64'd0};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.usr_req   = 1'b0;
        bus.usr_we    = 1'b0;
        bus.usr_addr  = '0;
        bus.usr_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.mem_re, bus.mem_we, bus.usr_rvalid, bus.usr_gnt} !== 4'b0000)
            $display("[TB] FAIL reset_enables: got %b expected 0000",
                     {bus.mem_re, bus.mem_we, bus.usr_rvalid, bus.usr_gnt});
        else n_pass++;
        n_checks++;
        if ({bus.mem_raddr, bus.mem_waddr} !== 14'd0)
            $display("[TB] FAIL reset_addr: got %h expected 0", {bus.mem_raddr, bus.mem_waddr});
        else n_pass++;
        n_checks++;
        if (bus.mem_in !== 64'd0 || bus.usr_rdata !== 64'd0)
            $display("[TB] FAIL reset_data: got %h/%h expected 0", bus.mem_in, bus.usr_rdata);
        else n_pass++;
        n_checks++;
        if ({ref_busy, ref_overrun} !== 2'b00)
            $display("[TB] FAIL reset_status: got %b expected 00", {ref_busy, ref_overrun});
        else n_pass++;
    endtask

    task automatic test_refresh_sequence();
        logic [80:0] exp_v, obs_v;
        do_reset();
        for (int c = 1; c <= 2 * ROWS * 15 + 5; c++) begin
            next_cycle();
            @(negedge clk);
            exp_v = idle_expect(c, -1, 64'd0, 1'b0);
            obs_v = observe();
            n_checks++;
            if (obs_v !== exp_v)
                $display("[TB] FAIL refresh_seq c=%0d: got %h expected %h", c, obs_v, exp_v);
            else n_pass++;
        end
        n_checks++;
        if (ref_overrun !== 1'b0)
            $display("[TB] FAIL refresh_overrun: got %b expected 0", ref_overrun);
        else n_pass++;
    endtask

    task automatic test_dirty_skip();
        logic [80:0] exp_v, obs_v;
        logic [63:0] wdat;
        wdat = 64'h0BAD_F00D_0000_0003;
        do_reset();
        for (int c = 1; c <= 132 * 15 + 5; c++) begin
            next_cycle();
            if (c == 1) begin
                bus.usr_req = 1'b1; bus.usr_we = 1'b1;
                bus.usr_addr = 7'd3; bus.usr_wdata = wdat;
            end else begin
                bus.usr_req = 1'b0; bus.usr_we = 1'b0;
            end
            @(negedge clk);
            if (c == 2) exp_v = {1'b0, 1'b0, 1'b1, 7'd0, 7'd3, wdat};
            else        exp_v = idle_expect(c, 4, wdat, 1'b1);
            obs_v = observe();
            n_checks++;
            if (obs_v !== exp_v)
                $display("[TB] FAIL dirty_skip c=%0d: got %h expected %h", c, obs_v, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        bit          eg [0:200];
        logic [6:0]  ah [0:200];
        logic        exp_re, exp_rv;
        logic [6:0]  exp_ra, obs_ra;
        int          k;
        do_reset();
        for (int c = 0; c <= 200; c++) begin
            if (c > 0) next_cycle();
            k = c % 128;
            bus.usr_req = 1'b1; bus.usr_we = 1'b0; bus.usr_addr = k[6:0];
            ah[c] = k[6:0];
            eg[c] = !(c >= 60 && ((c - 60) % 15) <= 3);
            @(negedge clk);
            n_checks++;
            if (bus.usr_gnt !== eg[c])
                $display("[TB] FAIL b2b_gnt c=%0d: got %b expected %b", c, bus.usr_gnt, eg[c]);
            else n_pass++;
            exp_re = 1'b0; exp_ra = 7'd0;
            if (c >= 1 && eg[c-1]) begin
                exp_re = 1'b1; exp_ra = ah[c-1];
            end else if (c >= 61 && ((c - 61) % 15) == 0) begin
                k = (c - 61) / 15;
                exp_re = 1'b1; exp_ra = k[6:0];
            end
            obs_ra = bus.mem_re ? bus.mem_raddr : 7'd0;
            n_checks++;
            if ({bus.mem_re, obs_ra} !== {exp_re, exp_ra})
                $display("[TB] FAIL b2b_memre c=%0d: got %b/%0d expected %b/%0d",
                         c, bus.mem_re, obs_ra, exp_re, exp_ra);
            else n_pass++;
            exp_rv = (c >= 2) && eg[c-2];
            n_checks++;
            if (bus.usr_rvalid !== exp_rv)
                $display("[TB] FAIL b2b_rvalid c=%0d: got %b expected %b", c, bus.usr_rvalid, exp_rv);
            else n_pass++;
        end
        bus.usr_req = 1'b0;
        n_checks++;
        if (ref_overrun !== 1'b0)
            $display("[TB] FAIL b2b_overrun: got %b expected 0", ref_overrun);
        else n_pass++;
    endtask

    task automatic test_write_read();
        logic [63:0] d;
        d = 64'hDEADBEEF_00000005;
        do_reset();
        next_cycle();
        bus.usr_req = 1'b1; bus.usr_we = 1'b1; bus.usr_addr = 7'd5; bus.usr_wdata = d;
        @(negedge clk);
        n_checks++;
        if (bus.usr_gnt !== 1'b1)
            $display("[TB] FAIL wr_gnt: got %b expected 1", bus.usr_gnt);
        else n_pass++;
        next_cycle();
        bus.usr_we = 1'b0; bus.usr_wdata = '0;
        @(negedge clk);
        n_checks++;
        if (bus.usr_gnt !== 1'b1)
            $display("[TB] FAIL rd_gnt: got %b expected 1", bus.usr_gnt);
        else n_pass++;
        n_checks++;
        if ({bus.mem_we, bus.mem_re, bus.mem_waddr, bus.mem_in} !== {1'b1, 1'b0, 7'd5, d})
            $display("[TB] FAIL wr_macro: got we=%b re=%b a=%0d d=%h expected we=1 re=0 a=5 d=%h",
                     bus.mem_we, bus.mem_re, bus.mem_waddr, bus.mem_in, d);
        else n_pass++;
        next_cycle();
        bus.usr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.mem_re, bus.mem_we, bus.mem_raddr, bus.usr_rvalid} !== {1'b1, 1'b0, 7'd5, 1'b0})
            $display("[TB] FAIL rd_macro: got re=%b we=%b a=%0d rv=%b expected re=1 we=0 a=5 rv=0",
                     bus.mem_re, bus.mem_we, bus.mem_raddr, bus.usr_rvalid);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if ({bus.usr_rvalid, bus.usr_rdata} !== {1'b1, d})
            $display("[TB] FAIL rd_data: got rv=%b d=%h expected rv=1 d=%h",
                     bus.usr_rvalid, bus.usr_rdata, d);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.usr_rvalid !== 1'b0)
            $display("[TB] FAIL rd_strobe_len: got %b expected 0", bus.usr_rvalid);
        else n_pass++;
    endtask

    task automatic test_reset_mid_refresh();
        logic [6:0] obs_ra;
        do_reset();
        for (int c = 1; c <= 46; c++) begin
            next_cycle();
            @(negedge clk);
        end
        n_checks++;
        if ({bus.mem_re, bus.mem_raddr, ref_busy} !== {1'b1, 7'd2, 1'b1})
            $display("[TB] FAIL mid_pre: got re=%b a=%0d busy=%b expected re=1 a=2 busy=1",
                     bus.mem_re, bus.mem_raddr, ref_busy);
        else n_pass++;
        next_cycle();
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.mem_re, bus.mem_we, ref_busy, bus.usr_rvalid, bus.usr_gnt, bus.mem_raddr,
             bus.mem_waddr, bus.mem_in} !== {5'b0, 7'd0, 7'd0, 64'd0})
            $display("[TB] FAIL mid_async: got re=%b we=%b busy=%b a=%0d d=%h expected all 0",
                     bus.mem_re, bus.mem_we, ref_busy, bus.mem_raddr, bus.mem_in);
        else n_pass++;
        next_cycle();
        @(negedge clk);
        n_checks++;
        if (bus.mem_we !== 1'b0)
            $display("[TB] FAIL mid_no_wb: got %b expected 0", bus.mem_we);
        else n_pass++;
        next_cycle();
        rst_n = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            next_cycle();
            @(negedge clk);
            obs_ra = bus.mem_re ? bus.mem_raddr : 7'd0;
            n_checks++;
            if ({bus.mem_re, obs_ra} !== {(c == 16), 7'd0})
                $display("[TB] FAIL mid_restart c=%0d: got %b/%0d expected %b/0",
                         c, bus.mem_re, obs_ra, (c == 16));
            else n_pass++;
        end
    endtask

    task automatic test_overrun();
        @(posedge clk);
        #1 rst_n_f = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            next_cycle();
            @(negedge clk);
            if (c == 17) begin
                n_checks++;
                if (ref_overrun_f !== 1'b0)
                    $display("[TB] FAIL overrun_early: got %b expected 0", ref_overrun_f);
                else n_pass++;
            end
            if (c >= 18) begin
                n_checks++;
                if (ref_overrun_f !== 1'b1)
                    $display("[TB] FAIL overrun_sticky c=%0d: got %b expected 1", c, ref_overrun_f);
                else n_pass++;
            end
        end
        next_cycle();
        rst_n_f = 1'b0;
        #1;
        n_checks++;
        if (ref_overrun_f !== 1'b0)
            $display("[TB] FAIL overrun_clear: got %b expected 0", ref_overrun_f);
        else n_pass++;
    endtask

    initial begin
        bus.usr_req   = 1'b0;
        bus.usr_we    = 1'b0;
        bus.usr_addr  = '0;
        bus.usr_wdata = '0;
        $display("[TB] start");
        test_reset();
        test_refresh_sequence();
        test_dirty_skip();
        test_back_to_back();
        test_write_read();
        test_reset_mid_refresh();
        test_overrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/gc_dram_refresh_ctrl.md
Name: gc_dram_refresh_ctrl

Overview:
- Front-end controller for the 128x64 gain-cell DRAM macro.
- Arbitrates single-port user read/write requests against periodic row refresh, issued as a read followed by a write-back.
- Rows fail 5000 cycles after their last write.
- Dirty-row skip: a row written by the user since the refresh pointer last passed it is not refreshed on the next visit, saving macro bandwidth.

Parameters:
ROWS, 128, number of rows; refresh pointer wraps at ROWS-1
ADDR_W, 7, row address width
DATA_W, 64, row data width
REFRESH_INTERVAL, 15, cycles per refresh credit; 2*ROWS*REFRESH_INTERVAL + MAX_CREDIT*REFRESH_INTERVAL must stay below 5000
MAX_CREDIT, 4, credit saturation level; reaching it forces refresh over user traffic

Ports:
clk  in  1  clock; all state on rising edge
rst_n  in  1  asynchronous active-low reset
usr_req  in  1  user request valid
usr_we  in  1  1 = write, 0 = read
usr_addr  in  ADDR_W  user row address
usr_wdata  in  DATA_W  user write data
usr_gnt  out  1  combinational grant; request accepted when usr_req && usr_gnt
usr_rdata  out  DATA_W  read data, valid while usr_rvalid
usr_rvalid  out  1  read data valid strobe
mem_re  out  1  macro read enable (registered)
mem_we  out  1  macro write enable (registered)
mem_raddr  out  ADDR_W  macro read address (registered)
mem_waddr  out  ADDR_W  macro write address (registered)
mem_in  out  DATA_W  macro write data (registered)
mem_rd  in  DATA_W  macro read data, valid the cycle after mem_re
ref_busy  out  1  high in REF_RD, REF_CAP, REF_WB
ref_overrun  out  1  sticky: a credit tick occurred while credits == MAX_CREDIT

Behaviour:
- Reset (async, any state): state=IDLE, tick=0, credits=0, ptr=0, dirty[ROWS-1:0]=0; all outputs 0; ref_overrun=0.
- Tick counter: 0..REFRESH_INTERVAL-1, free-running.
  - On wrap, credits++ saturating at MAX_CREDIT; if already MAX_CREDIT, set ref_overrun.
  - A same-cycle credit increment and consume nets to no change.
- FSM states: IDLE, REF_RD, REF_CAP, REF_WB.
- IDLE decision, in priority order:
  - credits>0 && (!usr_req || credits==MAX_CREDIT) && dirty[ptr]: skip. Clear dirty[ptr], credits--, ptr++ with wrap; no macro access; usr_gnt=0; stay IDLE.
  - credits>0 && (!usr_req || credits==MAX_CREDIT) && !dirty[ptr]: go to REF_RD; usr_gnt=0; credits--.
  - Otherwise usr_gnt=usr_req.
- Accepted user op in cycle k:
  - Read: mem_re=1, mem_raddr=usr_addr in cycle k+1. usr_rvalid=1 in cycle k+2, with usr_rdata=mem_rd (pass-through).
  - Write: mem_we=1, mem_waddr=usr_addr, mem_in=usr_wdata in cycle k+1; dirty[usr_addr] set at the end of cycle k.
  - Back-to-back grants allowed; each accepted op drives exactly one enable for one cycle.
- Refresh sequence, atomic, usr_gnt=0 throughout:
  - REF_RD: mem_re=1, mem_raddr=ptr.
  - REF_CAP: capture mem_rd.
  - REF_WB: mem_we=1, mem_waddr=ptr, mem_in=captured; ptr++ with wrap at ROWS-1 to 0.
  - REF_WB returns to IDLE.
  - usr_rvalid is never asserted for refresh reads.
- Macro safety: mem_re and mem_we are never both high with mem_raddr==mem_waddr. A user op granted in cycle k-1 completes at the macro before REF_RD starts at k+1.
- Write to row ptr during a refresh is impossible because no grant occurs in refresh states. Write to row ptr while IDLE sets its dirty bit, so that row is skipped on the next visit.
- Dirty bits are cleared only by a skip of that row, or by reset.
- Reset mid-refresh: sequence abandoned; mem_we returns to 0 immediately; ptr returns to 0.

Test Plan:
- Reset, no user traffic, 15*128*2 cycles -> credit ticks at cycles 15,30,...; each triggers REF_RD/REF_CAP/REF_WB on rows 0,1,2,... in order; ptr wraps 127->0; ref_overrun=0.
- Write 0xDEADBEEF_00000005 to row 5, then read row 5 -> usr_rvalid exactly 2 cycles after the read grant, with usr_rdata=0xDEADBEEF_00000005; mem_we asserted 1 cycle after the write grant.
- Write row 3 while ptr=0, then idle -> row 3 visit is a one-cycle skip with no mem_re/mem_we; dirty[3] cleared; the next visit to row 3 performs a full refresh.
- usr_req held high continuously (reads) -> no refresh until credits==4, then forced refresh; usr_gnt=0 for 4 cycles per forced refresh; ref_overrun stays 0.
- Hold credits at 4 by forcing ticks while the FSM is held busy (bench-driven stall via constant REF sequence) -> ref_overrun=1 and stays 1 until rst_n=0.
- Assert rst_n=0 during REF_CAP -> all outputs 0 in the same cycle, no write-back occurs; after release ptr=0, credits=0.
